// File: rtl/reset_seq_ctrl.sv
// Staged reset sequencer: holds all domains in reset, then releases them one by one from bit 0 upward.
// Define RST_SEQ_CAUSE_LOG_EN to enable the last_cause / rst_count logging registers.
module reset_seq_ctrl #(
  parameter int unsigned NUM_STAGES  = 3,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned GAP_CYCLES  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sw_rst_req,
  input  logic                  wdt_rst_req,
  input  logic                  ext_rst_req,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  seq_busy,
  output logic                  seq_done,
  output logic [2:0]            last_cause,
  output logic [7:0]            rst_count
);

  localparam int unsigned HW = $clog2(HOLD_CYCLES) + 1;
  localparam int unsigned GW = $clog2(GAP_CYCLES) + 1;
  localparam int unsigned IW = $clog2(NUM_STAGES) + 1;

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_STAGES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, RELEASE, DONE} state_t;

  state_t                state, state_nx;
  logic [HW-1:0]         hold_cnt, hold_cnt_nx;
  logic [GW-1:0]         gap_cnt, gap_cnt_nx;
  logic [IW-1:0]         stage_idx, stage_idx_nx;
  logic [NUM_STAGES-1:0] stage_q, stage_nx;
  logic                  any_req;

  assign any_req = sw_rst_req | wdt_rst_req | ext_rst_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HOLD;
      hold_cnt  <= '0;
      gap_cnt   <= '0;
      stage_idx <= '0;
      stage_q   <= '0;
    end else begin
      state     <= state_nx;
      hold_cnt  <= hold_cnt_nx;
      gap_cnt   <= gap_cnt_nx;
      stage_idx <= stage_idx_nx;
      stage_q   <= stage_nx;
    end
  end

  // hold_cnt holds the number of hold cycles already spent including the current one;
  // reset leaves it at 0 so the first cycle after reset is not counted.
  always_comb begin
    state_nx     = state;
    hold_cnt_nx  = hold_cnt;
    gap_cnt_nx   = gap_cnt;
    stage_idx_nx = stage_idx;
    stage_nx     = stage_q;
    if (any_req) begin
      state_nx     = HOLD;
      hold_cnt_nx  = HW'(1);
      gap_cnt_nx   = '0;
      stage_idx_nx = '0;
      stage_nx     = '0;
    end else begin
      case (state)
        IDLE: ;
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state_nx     = RELEASE;
            stage_nx     = NUM_STAGES'(1);
            stage_idx_nx = '0;
            gap_cnt_nx   = GW'(1);
          end else begin
            hold_cnt_nx = hold_cnt + HW'(1);
          end
        end
        RELEASE: begin
          if (stage_idx == IDX_LAST) begin
            state_nx = DONE;
          end else if (gap_cnt == GAP_LAST) begin
            stage_nx     = (stage_q << 1) | NUM_STAGES'(1);
            stage_idx_nx = stage_idx + IW'(1);
            gap_cnt_nx   = GW'(1);
          end else begin
            gap_cnt_nx = gap_cnt + GW'(1);
          end
        end
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  assign stage_rst_n = stage_q;
  assign seq_busy    = (state == HOLD) || (state == RELEASE);
  assign seq_done    = (state == DONE);

`ifdef RST_SEQ_CAUSE_LOG_EN
  logic [2:0] cause_q;
  logic [7:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cause_q <= '0;
      count_q <= '0;
    end else begin
      if (any_req)
        cause_q <= {ext_rst_req, wdt_rst_req, sw_rst_req};
      if ((state == DONE) && (count_q != '1))
        count_q <= count_q + 8'd1;
    end
  end

  assign last_cause = cause_q;
  assign rst_count  = count_q;
`else
  assign last_cause = '0;
  assign rst_count  = '0;
`endif

endmodule
